seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
Receive side of the team's seven-segment display interface. Samples a multiplexed display bus (one-hot digit anodes plus 7 segment lines) and debounces each digit's pattern. Decodes each stable pattern back to its 4-bit hex value. Publishes complete multi-digit frames through a valid/ready handshake, for display self-check and loopback test harnesses.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anode width), 1..8
STABLE_CYCLES, 8, consecutive identical samples required before capture, >=2
CNT_W (localparam), $clog2(STABLE_CYCLES+1), stability counter width

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
an_i  input  NUM_DIGITS  digit select; one-hot when valid, active-high
seg_i  input  7  segments, bit6=a ... bit0=g, active-high
digits_o  output  4*NUM_DIGITS  live decoded nibbles; digit d at [4d+3:4d]
digit_valid_o  output  NUM_DIGITS  digit d captured at least once since reset
frame_o  output  4*NUM_DIGITS  frame snapshot, held while frame_valid_o=1
frame_valid_o  output  1  snapshot available
frame_ready_i  input  1  consumer accepts snapshot
err_o  output  1  one-cycle pulse: stable pattern not in decode table

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0, FSM IDLE, counter 0, captured mask 0.
- an_i and seg_i are registered once (sample stage). All decisions use the registered values.
- Decode table, nibble:pattern: 0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111 7:1110000 8:1111111 9:1111011 A:1110111 B:0011111 C:1001110 D:0111101 E:1001111 F:1000111. Any other pattern is invalid.
- FSM states:
  - IDLE: sampled anode is zero or multi-hot. Counter held at 0.
  - TRACK: sampled anode is one-hot. Counter increments while (anode, seg) equal the previous sample. Any change restarts the counter at 1 with the new values.
  - HOLD: digit already captured in this dwell. Stays in HOLD until anode or seg changes. A seg change with the same anode returns to TRACK, so the digit can be recaptured. An anode change to another one-hot value goes to TRACK. Zero or multi-hot goes to IDLE.
- Capture occurs when the counter reaches STABLE_CYCLES.
  - Valid pattern: write the nibble to digits_o for the active digit, set its digit_valid_o bit and captured-mask bit, go to HOLD.
  - Invalid pattern: pulse err_o for 1 cycle, leave digits_o unchanged, go to HOLD.
- Latency: inputs that settle before edge k are reflected on digits_o after edge k+STABLE_CYCLES.
- Frame handshake:
  - When the captured mask is all ones and frame_valid_o=0: copy digits_o (including a capture landing in the same cycle) into frame_o, set frame_valid_o, clear the mask.
  - frame_o and frame_valid_o stay stable until frame_valid_o & frame_ready_i. frame_valid_o clears on that edge.
  - Captures continue into digits_o and the mask while a frame is pending.
  - If the mask is already full when the accept happens, the next snapshot is presented on the following cycle.
- frame_ready_i is ignored while frame_valid_o=0.
- Reset mid-operation: immediate return to reset values. Any pending frame is discarded.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: an_i and seg_i are inverted at the sample stage, for common-anode displays with active-low drive. All other behaviour, the table and the test values are unchanged after inversion.
- Undefined: active-high inputs as specified above.

Test Plan:
1. an_i=0001, seg_i=1111001 held 8 cycles -> after the 9th edge digits_o[3:0]=3, digit_valid_o=0001, err_o=0.
2. an_i=0010, seg_i toggles between 0110000 and 1101101 every 5 cycles -> digit 1 never captured, digit_valid_o[1]=0.
3. Scan 0001/0010/0100/1000 with patterns 1,2,A,F, dwell 12 cycles each, frame_ready_i=0 -> frame_valid_o=1, frame_o=16'hFA21, stable for 50 cycles. Raise frame_ready_i -> frame_valid_o drops next cycle, then the next frame appears after a full rescan.
4. an_i=0100, seg_i=1010101 held 10 cycles -> exactly one err_o pulse, digits_o[11:8] unchanged.
5. an_i=0011 (multi-hot) with a valid pattern for 20 cycles -> no capture, no err_o, FSM stays in IDLE.
6. Assert rst_ni=0 mid-dwell with a frame pending -> all outputs 0 immediately. After release, case 1 repeats with identical timing.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// ============================================================================
//  Module   : seg_scan_decoder
//  Purpose  : Samples a multiplexed seven-segment bus, debounces each digit,
//             decodes it to hex and publishes whole frames over valid/ready.
//  Options  : SEG_ACTIVE_LOW_EN - invert an_i/seg_i at the sample stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic [4*NUM_DIGITS-1:0] frame_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    err_o
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Sample stage
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_an_in;
  logic [6:0]            w_seg_in;

`ifdef SEG_ACTIVE_LOW_EN
  assign w_an_in  = ~an_i;
  assign w_seg_in = ~seg_i;
`else
  assign w_an_in  = an_i;
  assign w_seg_in = seg_i;
`endif

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an_prev;
  logic [6:0]            r_seg_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_an       <= '0;
      r_seg      <= '0;
      r_an_prev  <= '0;
      r_seg_prev <= '0;
    end else begin
      r_an       <= w_an_in;
      r_seg      <= w_seg_in;
      r_an_prev  <= r_an;
      r_seg_prev <= r_seg;
    end
  end

  logic w_onehot;
  logic w_same;

  assign w_onehot = $onehot(r_an);
  assign w_same   = (r_an == r_an_prev) && (r_seg == r_seg_prev);

  // --------------------------------------------------------------------------
  // Stability FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // The counter never exceeds STABLE_CYCLES-1 while tracking, so +1 cannot wrap.
  assign w_cnt_inc = r_cnt + C_ONE;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_state_nx = S_TRACK;
          w_cnt_nx   = C_ONE;
        end else begin
          w_cnt_nx   = '0;
        end
      end
      S_TRACK: begin
        if (!w_onehot) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_same) begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == C_STABLE) begin
            w_cap      = 1'b1;
            w_state_nx = S_HOLD;
          end
        end else begin
          w_cnt_nx = C_ONE;
        end
      end
      S_HOLD: begin
        if (!w_onehot) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (!w_same) begin
          w_state_nx = S_TRACK;
          w_cnt_nx   = C_ONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pattern decode (segment order a..g, bit 6 = a)
  // --------------------------------------------------------------------------
  logic [3:0] w_nib;
  logic       w_pat_ok;

  always_comb begin
    w_nib    = 4'h0;
    w_pat_ok = 1'b1;
    case (r_seg)
      7'b1111110: w_nib = 4'h0;
      7'b0110000: w_nib = 4'h1;
      7'b1101101: w_nib = 4'h2;
      7'b1111001: w_nib = 4'h3;
      7'b0110011: w_nib = 4'h4;
      7'b1011011: w_nib = 4'h5;
      7'b1011111: w_nib = 4'h6;
      7'b1110000: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1111011: w_nib = 4'h9;
      7'b1110111: w_nib = 4'hA;
      7'b0011111: w_nib = 4'hB;
      7'b1001110: w_nib = 4'hC;
      7'b0111101: w_nib = 4'hD;
      7'b1001111: w_nib = 4'hE;
      7'b1000111: w_nib = 4'hF;
      default:    w_pat_ok = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture, frame snapshot and handshake
  // --------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [4*NUM_DIGITS-1:0] w_digits_nx;
  logic [NUM_DIGITS-1:0]   r_dvalid;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [NUM_DIGITS-1:0]   w_mask_nx;
  logic [NUM_DIGITS-1:0]   w_cap_bits;
  logic [4*NUM_DIGITS-1:0] r_frame;
  logic                    r_fvalid;
  logic                    r_err;
  logic                    w_snap;

  // Sampled anode is one-hot whenever w_cap is set, so it selects the digit.
  assign w_cap_bits = (w_cap && w_pat_ok) ? r_an : '0;
  assign w_mask_nx  = r_mask | w_cap_bits;
  assign w_snap     = (&w_mask_nx) && !r_fvalid;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    assign w_digits_nx[4*d +: 4] = w_cap_bits[d] ? w_nib : r_digits[4*d +: 4];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_digits <= '0;
      r_dvalid <= '0;
      r_mask   <= '0;
      r_frame  <= '0;
      r_fvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_digits <= w_digits_nx;
      r_dvalid <= r_dvalid | w_cap_bits;
      r_err    <= w_cap && !w_pat_ok;
      if (w_snap) begin
        r_frame  <= w_digits_nx;
        r_fvalid <= 1'b1;
        r_mask   <= '0;
      end else begin
        r_mask <= w_mask_nx;
        if (r_fvalid && frame_ready_i) begin
          r_fvalid <= 1'b0;
        end
      end
    end
  end

  assign digits_o      = r_digits;
  assign digit_valid_o = r_dvalid;
  assign frame_o       = r_frame;
  assign frame_valid_o = r_fvalid;
  assign err_o         = r_err;

endmodule

`default_nettype wire
